// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard / stall controller for the 5-stage CPU.
// Combinational hold, bubble and flush controls for the pipeline registers.
// A small wait FSM tracks stalled data-RAM accesses and raises a sticky
// timeout. Two performance counters count stall and flush cycles.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_rR1,
  input  logic [4:0]       id_rR2,
  input  logic             ex_valid,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wR,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             perf_clr,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] TO = TIMEOUT[15:0];

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q;
  logic [15:0]      wait_cnt_q;
  logic [15:0]      wait_cnt_d;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic mem_stall;
  logic br_flush;
  logic lu_hazard;

  assign mem_stall = mem_req & ~mem_ack;
  assign br_flush  = ex_valid & ex_br_taken & ~mem_stall;
  assign lu_hazard = ex_valid & ex_is_load & ex_rf_we & (ex_wR != 5'd0) & id_valid &
                     ((id_re1 & (id_rR1 == ex_wR)) | (id_re2 & (id_rR2 == ex_wR)));

  // Priority encode of the pipeline controls: RAM wait, then redirect, then load-use.
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    idex_hold    = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (!cpu_rst) begin
      if (mem_stall) begin
        pc_hold      = 1'b1;
        ifid_hold    = 1'b1;
        idex_hold    = 1'b1;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
      end else if (br_flush) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu_hazard) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  // Saturating increment of the wait count while in MEM_WAIT.
  always_comb begin
    wait_cnt_d = (wait_cnt_q >= TO) ? TO : wait_cnt_q + 16'd1;
  end

  // Wait FSM: the count equals the number of consecutive stalled edges, and the
  // timeout is flagged on the edge that brings it up to TIMEOUT.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= 16'd1;
            if (TO == 16'd1) timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= 16'd0;
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == TO) timeout_q <= 1'b1;
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 16'd0;
        end
      endcase
    end
  end

  // Performance counters; a clear wins over a same-cycle increment.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_hold)    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_flush) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
